// File: rtl/flash_prog_seq_pkg.sv
// Shared types and constants for the multi-page flash programming sequencer.
package flash_prog_seq_pkg;

    typedef enum logic [7:0] {
        ST_IDLE   = 8'b0000_0001,
        ST_WREN_E = 8'b0000_0010,
        ST_ERASE  = 8'b0000_0100,
        ST_WREN_P = 8'b0000_1000,
        ST_PROG   = 8'b0001_0000,
        ST_VERIFY = 8'b0010_0000,
        ST_NEXT   = 8'b0100_0000,
        ST_ERR    = 8'b1000_0000
    } state_t;

    typedef struct packed {
        logic wren;
        logic erase;
        logic write;
    } flash_req_t;

    localparam flash_req_t REQ_NONE  = '{wren: 1'b0, erase: 1'b0, write: 1'b0};
    localparam flash_req_t REQ_WREN  = '{wren: 1'b1, erase: 1'b0, write: 1'b0};
    localparam flash_req_t REQ_ERASE = '{wren: 1'b0, erase: 1'b1, write: 1'b0};
    localparam flash_req_t REQ_WRITE = '{wren: 1'b0, erase: 1'b0, write: 1'b1};

    localparam int         PAGE_BYTES       = 256;
    localparam logic [7:0] SECTOR_PAGE_MASK = 8'hFF;
    localparam logic [8:0] WRITE_SIZE       = 9'd256;
    localparam logic [9:0] READ_SIZE        = 10'd256;

    // A page opens a new 64 KB sector when its page-within-sector index is zero.
    function automatic logic sector_start(input logic [23:0] addr);
        return (addr[15:8] & SECTOR_PAGE_MASK) == 8'h00;
    endfunction

endpackage

// File: rtl/flash_prog_seq_wdog.sv
// Per-step watchdog: counts cycles spent in a waiting state, restarted on each state change.
module flash_prog_seq_wdog #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd700_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [31:0] cnt;

    // clear is high during the first cycle of a new state, so that cycle counts as one.
    always_ff @(posedge sys_clk) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= enable ? 32'd1 : 32'd0;
        else if (enable && cnt != 32'hFFFF_FFFF)
            cnt <= cnt + 32'd1;
    end

    assign expire = enable && !clear && (cnt >= TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/flash_prog_seq.sv
// Multi-page flash programming sequencer driving flash_contorl request/end handshakes.
// Define FLASH_PROG_SEQ_VERIFY_EN to add a read-back checksum verify after each page.
module flash_prog_seq
    import flash_prog_seq_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd700_000_000,
    parameter int          PAGE_CNT_W     = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [23:0]           start_addr,
    input  logic [PAGE_CNT_W-1:0] page_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic [7:0]            src_data,
    output logic                  src_ack,
    output logic                  write_enable_req,
    input  logic                  write_enable_end,
    output logic                  erase_sector_req,
    output logic [23:0]           erase_sector_addr,
    input  logic                  erase_sector_end,
    output logic                  write_req,
    output logic [23:0]           write_page,
    output logic [8:0]            write_size,
    output logic [7:0]            write_data,
`ifdef FLASH_PROG_SEQ_VERIFY_EN
    output logic                  read_req,
    output logic [23:0]           read_addr,
    output logic [9:0]            read_size,
    input  logic [7:0]            read_data,
    input  logic                  read_ack,
    input  logic                  read_end,
`endif
    input  logic                  write_ack,
    input  logic                  write_end
);

    state_t                state;
    flash_req_t            req;
    logic [23:0]           page_addr;
    logic [23:0]           next_page;
    logic [PAGE_CNT_W-1:0] remaining;
    logic                  wd_clr;
    logic                  wd_en;
    logic                  wd_expire;
    logic                  unused_addr_lo;

    assign next_page      = page_addr + 24'(PAGE_BYTES);
    assign wd_en          = state inside {ST_WREN_E, ST_ERASE, ST_WREN_P, ST_PROG, ST_VERIFY};
    assign unused_addr_lo = ^start_addr[7:0];

`ifdef FLASH_PROG_SEQ_VERIFY_EN
    logic       rd_req;
    logic [7:0] wr_sum;
    logic [7:0] rd_sum;
    logic [7:0] rd_sum_nxt;

    // Include a byte arriving in the same cycle as read_end in the final compare.
    assign rd_sum_nxt = rd_sum + (read_ack ? read_data : 8'h00);
    assign read_req   = rd_req;
    assign read_addr  = page_addr;
    assign read_size  = READ_SIZE;
`endif

    flash_prog_seq_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clear   (wd_clr),
        .enable  (wd_en),
        .expire  (wd_expire)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req       <= REQ_NONE;
            page_addr <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            wd_clr    <= 1'b0;
`ifdef FLASH_PROG_SEQ_VERIFY_EN
            rd_req    <= 1'b0;
            wr_sum    <= '0;
            rd_sum    <= '0;
`endif
        end else begin
            done   <= 1'b0;
            error  <= 1'b0;
            wd_clr <= 1'b0;
            unique case (state)
                ST_IDLE: if (start) begin
                    if (page_count == '0) begin
                        done <= 1'b1;
                    end else begin
                        page_addr <= {start_addr[23:8], 8'h00};
                        remaining <= page_count;
                        busy      <= 1'b1;
                        req       <= REQ_WREN;
                        state     <= ST_WREN_E;
                        wd_clr    <= 1'b1;
                    end
                end
                // Only entered for the first page or a sector-opening page.
                ST_WREN_E: if (write_enable_end) begin
                    req <= REQ_ERASE; state <= ST_ERASE; wd_clr <= 1'b1;
                end else if (wd_expire) begin
                    req <= REQ_NONE; state <= ST_ERR; wd_clr <= 1'b1;
                end
                ST_ERASE: if (erase_sector_end) begin
                    req <= REQ_WREN; state <= ST_WREN_P; wd_clr <= 1'b1;
                end else if (wd_expire) begin
                    req <= REQ_NONE; state <= ST_ERR; wd_clr <= 1'b1;
                end
                ST_WREN_P: if (write_enable_end) begin
                    req <= REQ_WRITE; state <= ST_PROG; wd_clr <= 1'b1;
`ifdef FLASH_PROG_SEQ_VERIFY_EN
                    wr_sum <= '0;
`endif
                end else if (wd_expire) begin
                    req <= REQ_NONE; state <= ST_ERR; wd_clr <= 1'b1;
                end
                ST_PROG: begin
`ifdef FLASH_PROG_SEQ_VERIFY_EN
                    if (src_ack) wr_sum <= wr_sum + src_data;
`endif
                    if (write_end) begin
                        req    <= REQ_NONE;
                        wd_clr <= 1'b1;
`ifdef FLASH_PROG_SEQ_VERIFY_EN
                        rd_req <= 1'b1;
                        rd_sum <= '0;
                        state  <= ST_VERIFY;
`else
                        state  <= ST_NEXT;
`endif
                    end else if (wd_expire) begin
                        req <= REQ_NONE; state <= ST_ERR; wd_clr <= 1'b1;
                    end
                end
`ifdef FLASH_PROG_SEQ_VERIFY_EN
                ST_VERIFY: begin
                    if (read_ack) rd_sum <= rd_sum_nxt;
                    if (read_end) begin
                        rd_req <= 1'b0;
                        wd_clr <= 1'b1;
                        state  <= (rd_sum_nxt == wr_sum) ? ST_NEXT : ST_ERR;
                    end else if (wd_expire) begin
                        rd_req <= 1'b0; state <= ST_ERR; wd_clr <= 1'b1;
                    end
                end
`endif
                ST_NEXT: begin
                    page_addr <= next_page;
                    remaining <= remaining - PAGE_CNT_W'(1);
                    wd_clr    <= 1'b1;
                    if (remaining == PAGE_CNT_W'(1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        req   <= REQ_WREN;
                        state <= sector_start(next_page) ? ST_WREN_E : ST_WREN_P;
                    end
                end
                ST_ERR: begin
                    error  <= 1'b1;
                    busy   <= 1'b0;
                    req    <= REQ_NONE;
                    state  <= ST_IDLE;
                    wd_clr <= 1'b1;
`ifdef FLASH_PROG_SEQ_VERIFY_EN
                    rd_req <= 1'b0;
`endif
                end
                default: begin
                    req   <= REQ_NONE;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign write_enable_req  = req.wren;
    assign erase_sector_req  = req.erase;
    assign write_req         = req.write;
    assign erase_sector_addr = {page_addr[23:16], 16'h0000};
    assign write_page        = page_addr;
    assign write_size        = WRITE_SIZE;
    assign write_data        = src_data;
    assign src_ack           = req.write & write_ack;

endmodule
